// File: rtl/div_unit_pkg.sv
// Shared defines for the iterative divider: FSM state encodings, handshake
// levels and the result width constant.
package div_unit_pkg;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam int DivResultWidth = 64;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and emit the quotient bit.
// Output packing is {next partial remainder, quotient bit}.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   step
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_sub;

  // The trial remainder can reach WIDTH+1 bits, but whenever the subtract is
  // taken the difference is below the divisor, so WIDTH bits hold it exactly.
  always_comb begin
    shifted = {rem, bit_in};
    rem_sub = shifted[WIDTH-1:0] - divisor;
    if (shifted >= {1'b0, divisor}) begin
      step = {rem_sub, 1'b1};
    end else begin
      step = {shifted[WIDTH-1:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider (signed DIV / unsigned DIVU), one quotient bit
// per clock, 32 steps plus one fix-up edge.
// Optional feature: define DIV_ZERO_DETECT_EN to short-cut a zero divisor
// through the BYZERO state (result 0, ready one edge after acceptance).
// Without it a zero divisor runs the full 32 steps like any other operand.
//
// state      | meaning
// DivFree    | idle, outputs 0, waiting for start_i without annul_i
// DivByZero  | zero divisor detected (DIV_ZERO_DETECT_EN builds only)
// DivOn      | shift-subtract iterations, cnt counts completed steps
// DivEnd     | result valid, held until start_i drops
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  logic [1:0]       state;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic             neg_quot;
  logic             neg_rem;

  logic [WIDTH-1:0] op1_mag;
  logic [WIDTH-1:0] op2_mag;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH:0]   step;

  // Operand magnitudes at acceptance and sign fix-up of the finished result.
  // The most negative dividend maps onto itself, which is its correct
  // unsigned magnitude.
  always_comb begin
    op1_mag  = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    op2_mag  = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
    quot_fix = neg_quot ? (~quot + 1'b1) : quot;
    rem_fix  = neg_rem  ? (~rem + 1'b1)  : rem;
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem    (rem),
    .bit_in (dividend[WIDTH-1]),
    .divisor(divisor),
    .step   (step)
  );

  // Control FSM, iteration counter and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DivFree;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      quot     <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            dividend <= op1_mag;
            divisor  <= op2_mag;
            neg_quot <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem  <= signed_div_i & opdata1_i[WIDTH-1];
            rem      <= '0;
            quot     <= '0;
            cnt      <= '0;
`ifdef DIV_ZERO_DETECT_EN
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              state <= DivOn;
            end
`else
            state <= DivOn;
`endif
          end
        end
`ifdef DIV_ZERO_DETECT_EN
        DivByZero: begin
          if (annul_i) begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else begin
            state    <= DivEnd;
            result_o <= '0;
            ready_o  <= DivResultReady;
          end
        end
`endif
        DivOn: begin
          if (annul_i) begin
            state    <= DivFree;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else if (cnt == 6'd32) begin
            state    <= DivEnd;
            cnt      <= '0;
            result_o <= {rem_fix, quot_fix};
            ready_o  <= DivResultReady;
          end else begin
            rem      <= step[WIDTH:1];
            quot     <= {quot[WIDTH-2:0], step[0]};
            dividend <= {dividend[WIDTH-2:0], 1'b0};
            cnt      <= cnt + 6'd1;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end
        default: begin
          state    <= DivFree;
          result_o <= '0;
          ready_o  <= DivResultNotReady;
        end
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  one clock; reset is asynchronous and active-low.
REQ-004 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled only on the accepting edge.
REQ-005 opdata1_i  input  WIDTH  dividend; sampled only on the accepting edge.
REQ-006 opdata2_i  input  WIDTH  divisor; sampled only on the accepting edge.
REQ-007 start_i  input  1  request from the EX stage, held high until ready_o is seen.
REQ-008 annul_i  input  1  cancels the operation in flight (branch/exception flush).
REQ-009 result_o  output  2*WIDTH  registered result: {remainder (HI), quotient (LO)}.
REQ-010 ready_o  output  1  registered; 1 = result_o valid.

Function
REQ-011 The block SHALL have states FREE, BYZERO, ON and END, with a 6-bit iteration counter cnt.
REQ-012 FREE: on an edge with start_i=1 and annul_i=0 (edge E), the block SHALL latch the operands; else it stays in FREE with outputs 0.
REQ-013 On edge E with divisor 0 and DIV_ZERO_DETECT_EN defined, the block SHALL go to BYZERO; otherwise it SHALL go to ON with cnt=0.
REQ-014 BYZERO SHALL go to END on edge E+1 with result_o=0 and ready_o=1.
REQ-015 ON SHALL perform one restoring shift-subtract step per edge on E+1..E+32, incrementing cnt to 32.
REQ-016 On edge E+33, with cnt=32, the block SHALL apply sign fix-up, go to END, load result_o and set ready_o=1.
REQ-017 Signed mode SHALL divide magnitudes, negate the quotient when operand signs differ, and give the remainder the dividend's sign.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0, with no trap.
REQ-019 END SHALL hold result_o and ready_o stable while start_i=1.
REQ-020 When start_i=0 in END, the next edge SHALL go to FREE with result_o=0 and ready_o=0.
REQ-021 annul_i=1 in ON or BYZERO SHALL force FREE on the next edge, with outputs 0 and the partial result discarded.
REQ-022 annul_i SHALL be ignored in END.
REQ-023 The edge after a return to FREE SHALL be able to accept a new start; back-to-back operations SHALL be supported.
REQ-024 Operand input changes after edge E SHALL NOT affect the operation in flight.

Reset
REQ-025 While rst=0, the block SHALL immediately force state=FREE, cnt=0, result_o=0, ready_o=0 and the internal dividend/divisor registers to 0, including mid-operation.
REQ-026 The first acceptance after reset release SHALL be possible on the first rising edge with rst=1.

Configuration
REQ-027 Macro DIV_ZERO_DETECT_EN SHALL select divide-by-zero handling.
REQ-028 With DIV_ZERO_DETECT_EN defined: a zero divisor SHALL take the BYZERO path, giving result 0 with ready_o high after E+1.
REQ-029 Without DIV_ZERO_DETECT_EN: BYZERO SHALL be absent and a zero divisor SHALL run all 32 steps, giving quotient all-ones and remainder equal to the latched dividend magnitude, then the normal sign fix-up.

Structure
REQ-030 State encodings SHALL live in the shared defines file: DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
REQ-031 The shared defines file SHALL also hold DivResultReady/NotReady, DivStart/Stop and the 64-bit result width constant.
REQ-032 One combinational sub-module, div_step, SHALL compute one shift-compare-subtract step ({partial remainder, quotient bit}); the FSM, counter and sign fix-up SHALL stay in div_unit.

Verification
REQ-033 Unsigned 100/7, start held -> ready_o=1 after E+33, result_o=64'h00000002_0000000E.
REQ-034 Signed 0xFFFFFFFB/2 -> result_o=64'hFFFFFFFF_FFFFFFFE; signed 0x80000000/0xFFFFFFFF -> 64'h00000000_80000000.
REQ-035 0x1234/0 with macro -> ready after E+1, result 0; without macro -> ready after E+33, result 64'h00001234_FFFFFFFF.
REQ-036 annul_i pulsed at cnt=10 -> FREE next edge, ready_o=0, result_o=0; new 9/3 started on the following edge -> 64'h00000000_00000003.
REQ-037 start_i held 5 cycles in END -> result stable; start_i dropped -> outputs 0 after one edge; back-to-back second divide correct.
REQ-038 rst driven low at cnt=20 without a clock edge -> outputs 0 immediately; after release, 100/7 completes correctly.
